// File: rtl/cluster_pkg.sv
// Shared constants, types and helpers for the cluster pass sequencer.
package cluster_pkg;

    // Truncation passes per frame (160 MHz clocks per 40 MHz BX).
    localparam int MXPASSES    = 4;
    // Width of the pass index; 2**PASS_W must cover MXPASSES.
    localparam int PASS_W      = 3;
    // Priority-encoder pipeline depth; pass tags are delayed by this amount.
    localparam int ENC_LATENCY = 2;
    // Width of the saturating statistics counters.
    localparam int CNT_W       = 16;

    // Tag travelling alongside each pass through the encoder pipeline.
    typedef struct packed {
        logic              valid;
        logic              last;
        logic [PASS_W-1:0] idx;
    } pass_tag_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/pass_tag_delay.sv
// Fixed-depth shift register that aligns pass tags with the encoder output.
module pass_tag_delay
    import cluster_pkg::*;
#(
    parameter int DEPTH = ENC_LATENCY
) (
    input  logic      clock,
    input  logic      reset,
    input  pass_tag_t tag_in,
    output pass_tag_t tag_out
);

    pass_tag_t stage_r [DEPTH];

    // Shift one tag per clock; stage 0 takes the new tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/cluster_pass_sequencer.sv
// Generates the truncator latch pulse from the BX strobe, steps the pass index,
// tags passes valid/empty for the priority encoder and flags overflow frames.
module cluster_pass_sequencer
    import cluster_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              bx_strobe,
    input  logic              vpfs_any,
    input  logic              remain_any,
    input  logic              cnt_clear,
    output logic              latch_pulse,
    output logic [PASS_W-1:0] pass_o,
    output logic              pass_valid_dly,
    output logic [PASS_W-1:0] pass_idx_dly,
    output logic              frame_done_dly,
    output logic              overflow,
    output logic [CNT_W-1:0]  overflow_cnt,
    output logic [CNT_W-1:0]  collision_cnt
);

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(MXPASSES - 1);
    localparam logic [PASS_W-1:0] PRE_LAST  = PASS_W'(MXPASSES - 2);

    seq_state_t        state_r, state_s;
    logic              latch_r;
    logic [PASS_W-1:0] pass_r, pass_s;
    logic              active_r, active_s;   // current cycle is a real pass
    logic              empty_r, empty_s;     // sticky: frame already ran dry
    logic              overflow_r;
    logic [CNT_W-1:0]  ovf_cnt_r;
    logic [CNT_W-1:0]  col_cnt_r;

    logic              qual_strobe_s;
    logic              collision_s;
    logic              last_pass_s;
    logic              overflow_s;
    pass_tag_t         tag_s;
    pass_tag_t         tag_dly_s;

    // Decode strobe qualification, collisions and the pass tag for this cycle.
    always_comb begin
        qual_strobe_s = bx_strobe & enable;
        collision_s   = qual_strobe_s & (state_r == ST_RUN) & active_r & (pass_r < PRE_LAST);
        last_pass_s   = active_r & (pass_r == LAST_PASS);
        overflow_s    = last_pass_s & remain_any;
        tag_s         = '0;
        tag_s.valid   = active_r & vpfs_any & ~empty_r;
        tag_s.last    = last_pass_s;
        if (active_r) begin
            tag_s.idx = pass_r;
        end else begin
            tag_s.idx = '0;
        end
    end

    // Next pass index, pass-active flag and sticky-empty flag.
    always_comb begin
        pass_s   = pass_r;
        active_s = 1'b0;
        empty_s  = empty_r;
        if (latch_r) begin
            pass_s   = '0;
            active_s = 1'b1;
        end else if (collision_s) begin
            // Abandon the interrupted frame; the restart begins after the latch.
            pass_s   = pass_r;
            active_s = 1'b0;
        end else if (active_r && (pass_r != LAST_PASS)) begin
            pass_s   = pass_r + PASS_W'(1);
            active_s = 1'b1;
        end else begin
            pass_s   = pass_r;
            active_s = 1'b0;
        end

        if (latch_r) begin
            empty_s = 1'b0;
        end else if (active_r && !vpfs_any) begin
            empty_s = 1'b1;
        end else begin
            empty_s = empty_r;
        end
    end

    // Frame-level state: leave RUN once the last pass ends with no follow-on frame.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (qual_strobe_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_pass_s && !qual_strobe_s && !latch_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer registers: state, latch strobe, pass counter, overflow pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            latch_r    <= 1'b0;
            pass_r     <= '0;
            active_r   <= 1'b0;
            empty_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            latch_r    <= qual_strobe_s;
            pass_r     <= pass_s;
            active_r   <= active_s;
            empty_r    <= empty_s;
            overflow_r <= overflow_s;
        end
    end

    // Saturating statistics counters; clear wins over a same-cycle increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_cnt_r <= '0;
            col_cnt_r <= '0;
        end else if (cnt_clear) begin
            ovf_cnt_r <= '0;
            col_cnt_r <= '0;
        end else begin
            if (overflow_s) begin
                ovf_cnt_r <= sat_inc(ovf_cnt_r);
            end
            if (collision_s) begin
                col_cnt_r <= sat_inc(col_cnt_r);
            end
        end
    end

    pass_tag_delay #(
        .DEPTH (ENC_LATENCY)
    ) u_tag_delay (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_s),
        .tag_out (tag_dly_s)
    );

    assign latch_pulse    = latch_r;
    assign pass_o         = pass_r;
    assign pass_valid_dly = tag_dly_s.valid;
    assign pass_idx_dly   = tag_dly_s.idx;
    assign frame_done_dly = tag_dly_s.last;
    assign overflow       = overflow_r;
    assign overflow_cnt   = ovf_cnt_r;
    assign collision_cnt  = col_cnt_r;

endmodule
